// File: rtl/sha256_msg_padder.sv
// -----------------------------------------------------------------------------
// sha256_msg_padder
//
// Byte-stream front end for a SHA-256 compression core. Incoming message bytes
// are packed big-endian into 512-bit blocks (byte 0 lands in bits 511:504).
// The final block(s) of a message receive the standard SHA-256 trailer: a 0x80
// marker byte, zero fill, and the 64-bit message length in bits. A completed
// block is offered to the core with a one-cycle start pulse. The next block is
// only built after the core reports it has consumed the current one.
//
// Ports
//   Clk        : clock, all logic on the rising edge
//   Rst        : asynchronous reset, active high
//   i_Valid    : i_Byte carries a message byte this cycle
//   i_Byte     : message byte
//   i_fLast    : with i_Valid, marks the final byte of the message
//   i_fEmpty   : one-cycle request to hash the zero-length message (idle only)
//   o_Ready    : byte accepted on a cycle with i_Valid & o_Ready
//   o_Data     : 512-bit block to the core, held stable until the core is done
//   o_fStart   : one-cycle pulse telling the core to consume o_Data
//   o_fFirst   : with o_fStart, first block of a message (core loads its IV)
//   o_fFinal   : with o_fStart, last block of a message
//   i_fDone    : core has consumed the block (only observed while waiting)
//   o_fMsgDone : one-cycle pulse after the core finishes the final block
// -----------------------------------------------------------------------------
module sha256_msg_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         i_Valid,
    input  logic [7:0]   i_Byte,
    input  logic         i_fLast,
    input  logic         i_fEmpty,
    output logic         o_Ready,
    output logic [511:0] o_Data,
    output logic         o_fStart,
    output logic         o_fFirst,
    output logic         o_fFinal,
    input  logic         i_fDone,
    output logic         o_fMsgDone
);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_PAD  = 2'd3
    } state_t;

    // Extra trailer block still owed once the current block is consumed.
    typedef enum logic [1:0] {
        EX_NONE     = 2'd0,
        EX_LEN_ONLY = 2'd1,
        EX_MARK_LEN = 2'd2
    } extra_t;

    // Replace byte idx of a block (byte 0 = bits 511:504); idx 64 leaves it unchanged.
    function automatic logic [511:0] put_byte(input logic [511:0] blk,
                                              input logic [6:0]   idx,
                                              input logic [7:0]   val);
        logic [511:0] res;
        res = blk;
        for (int k = 0; k < 64; k++) begin
            if (idx == 7'(k)) begin
                res[511 - 8*k -: 8] = val;
            end
        end
        return res;
    endfunction

    // Zero-extend the internal bit counter into the 64-bit length field.
    function automatic logic [63:0] len_field(input logic [LEN_W-1:0] len);
        logic [63:0] res;
        res = 64'd0;
        res[LEN_W-1:0] = len;
        return res;
    endfunction

    state_t             state_q,     state_d;
    extra_t             extra_q,     extra_d;
    logic [5:0]         ptr_q,       ptr_d;
    logic [LEN_W-1:0]   len_q,       len_d;
    logic [511:0]       data_q,      data_d;
    logic               final_q,     final_d;      // current block is the message's last
    logic               msg_first_q, msg_first_d;  // next block sent opens a new message
    logic               start_q,     start_d;
    logic               out_first_q, out_first_d;
    logic               out_final_q, out_final_d;
    logic               msgdone_q,   msgdone_d;

    logic [LEN_W-1:0]   len_new_s;
    logic [6:0]         n_s;

    // Next-state and block composition.
    always_comb begin
        state_d     = state_q;
        extra_d     = extra_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        data_d      = data_q;
        final_d     = final_q;
        msg_first_d = msg_first_q;
        msgdone_d   = 1'b0;
        len_new_s   = len_q + LEN_W'(8);
        n_s         = {1'b0, ptr_q} + 7'd1;

        case (state_q)
            ST_FILL: begin
                if (i_Valid) begin
                    len_d  = len_new_s;
                    ptr_d  = ptr_q + 6'd1;
                    data_d = put_byte(data_q, {1'b0, ptr_q}, i_Byte);
                    if (i_fLast) begin
                        // Marker goes right after the last byte; a full block
                        // (n = 64) has no room and defers it to the extra block.
                        data_d  = put_byte(data_d, n_s, 8'h80);
                        state_d = ST_SEND;
                        if (n_s <= 7'd55) begin
                            data_d[63:0] = len_field(len_new_s);
                            final_d      = 1'b1;
                            extra_d      = EX_NONE;
                        end else if (n_s <= 7'd63) begin
                            final_d = 1'b0;
                            extra_d = EX_LEN_ONLY;
                        end else begin
                            final_d = 1'b0;
                            extra_d = EX_MARK_LEN;
                        end
                    end else if (ptr_q == 6'd63) begin
                        final_d = 1'b0;
                        extra_d = EX_NONE;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else if (i_fEmpty && (len_q == '0)) begin
                    data_d  = {8'h80, 504'd0};
                    final_d = 1'b1;
                    extra_d = EX_NONE;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_FILL;
                end
            end

            ST_SEND: begin
                msg_first_d = 1'b0;
                state_d     = ST_WAIT;
            end

            ST_WAIT: begin
                if (i_fDone) begin
                    ptr_d = 6'd0;
                    if (final_q) begin
                        msgdone_d   = 1'b1;
                        len_d       = '0;
                        msg_first_d = 1'b1;
                        data_d      = 512'd0;
                        state_d     = ST_FILL;
                    end else if (extra_q != EX_NONE) begin
                        state_d = ST_PAD;
                    end else begin
                        data_d  = 512'd0;
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_PAD: begin
                case (extra_q)
                    EX_MARK_LEN: data_d = {8'h80, 440'd0, len_field(len_q)};
                    EX_LEN_ONLY: data_d = {448'd0, len_field(len_q)};
                    default:     data_d = {448'd0, len_field(len_q)};
                endcase
                final_d = 1'b1;
                extra_d = EX_NONE;
                state_d = ST_SEND;
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase

        // Strobes are registered so they line up with the SEND state.
        start_d     = (state_d == ST_SEND);
        out_first_d = start_d & msg_first_q;
        out_final_d = start_d & final_d;
    end

    // State and datapath registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_FILL;
            extra_q     <= EX_NONE;
            ptr_q       <= 6'd0;
            len_q       <= '0;
            data_q      <= 512'd0;
            final_q     <= 1'b0;
            msg_first_q <= 1'b1;
            start_q     <= 1'b0;
            out_first_q <= 1'b0;
            out_final_q <= 1'b0;
            msgdone_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            extra_q     <= extra_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            data_q      <= data_d;
            final_q     <= final_d;
            msg_first_q <= msg_first_d;
            start_q     <= start_d;
            out_first_q <= out_first_d;
            out_final_q <= out_final_d;
            msgdone_q   <= msgdone_d;
        end
    end

    // Ready is gated by Rst so it drops the moment reset is applied.
    assign o_Ready    = (state_q == ST_FILL) & ~Rst;
    assign o_Data     = data_q;
    assign o_fStart   = start_q;
    assign o_fFirst   = out_first_q;
    assign o_fFinal   = out_final_q;
    assign o_fMsgDone = msgdone_q;

endmodule
